// File: rtl/inst_rom_fetch.sv
// Loadable instruction memory with a READ_LAT-deep valid/ready fetch pipeline,
// flush, and misaligned / out-of-range fault reporting.
module inst_rom_fetch #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_inst,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  generate
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("inst_rom_fetch: READ_LAT must be 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0]           mem [DEPTH];
  logic [DATA_W-1:0]           rd_data_reg;
  logic [DATA_W-1:0]           last_data;
  logic [READ_LAT-1:0]         valid_reg;
  logic [READ_LAT-1:0][1:0]    fault_reg;
  logic [1:0]                  req_fault;
  logic [1:0]                  last_fault;
  logic [DEPTH_LOG2-1:0]       req_idx;
  logic                        range_fault;
  logic                        advance;
  logic                        rd_en;

  assign req_idx      = req_addr[DEPTH_LOG2+1:2];
  assign req_fault[0] = |req_addr[1:0];
  assign req_fault[1] = range_fault;

  generate
    if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range
      assign range_fault = |req_addr[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_no_range
      assign range_fault = 1'b0;
    end
  endgenerate

  // The whole pipe moves as one; req_ready stays a two-gate path from rsp_ready/flush.
  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = rst_n && advance && !flush;
  assign rd_en     = req_ready && req_valid && (req_fault == 2'b00);

  // Reset-free block so the array and its read register map onto block RAM.
  // Non-blocking semantics give read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (ld_en && rst_n) begin
      mem[ld_addr] <= ld_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[req_idx];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] data_s1_reg;
      always_ff @(posedge clk) begin
        if (advance) begin
          data_s1_reg <= rd_data_reg;
        end
      end
      assign last_data = data_s1_reg;
    end else begin : g_lat1
      assign last_data = rd_data_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      fault_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (advance) begin
      valid_reg[0] <= req_valid;
      fault_reg[0] <= req_fault;
      for (int i = 1; i < READ_LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        fault_reg[i] <= fault_reg[i-1];
      end
    end
  end

  // Data path carries no reset, so outputs are masked by the stage valid and fault.
  assign rsp_valid  = valid_reg[READ_LAT-1];
  assign last_fault = fault_reg[READ_LAT-1];
  assign rsp_fault  = rsp_valid ? last_fault : 2'b00;
  assign rsp_inst   = (rsp_valid && last_fault == 2'b00) ? last_data : '0;

endmodule

// File: tb/tb_inst_rom_fetch.sv
// Directed bench driving a READ_LAT=1 and a READ_LAT=2 instance with shared stimulus.
module tb_inst_rom_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        a_req_ready, a_rsp_valid;
  logic [31:0] a_rsp_inst;
  logic [1:0]  a_rsp_fault;
  logic        b_req_ready, b_rsp_valid;
  logic [31:0] b_rsp_inst;
  logic [1:0]  b_rsp_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_rom_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(a_rsp_inst), .rsp_fault(a_rsp_fault),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_rom_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(8), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(b_rsp_inst), .rsp_fault(b_rsp_fault),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [31:0] inst, input logic [1:0] f);
    check({tag, ".lat1.valid"}, {31'd0, a_rsp_valid}, {31'd0, v});
    check({tag, ".lat1.inst"}, a_rsp_inst, inst);
    check({tag, ".lat1.fault"}, {30'd0, a_rsp_fault}, {30'd0, f});
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [31:0] inst, input logic [1:0] f);
    check({tag, ".lat2.valid"}, {31'd0, b_rsp_valid}, {31'd0, v});
    check({tag, ".lat2.inst"}, b_rsp_inst, inst);
    check({tag, ".lat2.fault"}, {30'd0, b_rsp_fault}, {30'd0, f});
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
    $display("load mem[%0d] = %h", a, d);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #2;
    check("reset.req_ready", {31'd0, a_req_ready}, 32'd0);
    chk_a("reset", 1'b0, 32'h0, 2'b00);
    chk_b("reset", 1'b0, 32'h0, 2'b00);
    step(); step();
    rst_n = 1'b1;

    load(8'd1, 32'h24210004);
    load(8'd2, 32'h00221820);
    load(8'd3, 32'h00000000);

    // Back-to-back fetches, no backpressure
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h4;
    #1 check("t1.req_ready", {31'd0, a_req_ready}, 32'd1);
    step();
    req_addr = 32'h8;
    chk_a("t1.r0", 1'b1, 32'h24210004, 2'b00);
    check("t1.lat2.empty", {31'd0, b_rsp_valid}, 32'd0);
    step();
    req_valid = 1'b0;
    chk_a("t1.r1", 1'b1, 32'h00221820, 2'b00);
    chk_b("t1.r0", 1'b1, 32'h24210004, 2'b00);
    step();
    chk_a("t1.idle", 1'b0, 32'h0, 2'b00);
    chk_b("t1.r1", 1'b1, 32'h00221820, 2'b00);
    step();
    chk_b("t1.idle", 1'b0, 32'h0, 2'b00);
    $display("txn t1: fetch 0x4,0x8 back-to-back");

    // Backpressure on the two-stage instance
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_addr = 32'h8;
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    check("t2.req_ready", {31'd0, b_req_ready}, 32'd0);
    chk_b("t2.head", 1'b1, 32'h24210004, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_b("t2.hold", 1'b1, 32'h24210004, 2'b00);
    end
    rsp_ready = 1'b1;
    #1 check("t2.req_ready_back", {31'd0, b_req_ready}, 32'd1);
    step();
    chk_b("t2.second", 1'b1, 32'h00221820, 2'b00);
    step();
    chk_b("t2.drained", 1'b0, 32'h0, 2'b00);
    step();
    $display("txn t2: backpressure 3 cycles then drain");

    // Faults
    req_valid = 1'b1; req_addr = 32'h6;
    step();
    req_addr = 32'h400;
    chk_a("t3.misalign", 1'b1, 32'h0, 2'b01);
    step();
    req_addr = 32'h402;
    chk_a("t3.range", 1'b1, 32'h0, 2'b10);
    step();
    req_valid = 1'b0;
    chk_a("t3.both", 1'b1, 32'h0, 2'b11);
    chk_b("t3.range", 1'b1, 32'h0, 2'b10);
    step();
    chk_b("t3.both", 1'b1, 32'h0, 2'b11);
    step();
    $display("txn t3: fault fetches 0x6,0x400,0x402");

    // Read/load collision
    ld_en = 1'b1; ld_addr = 8'd3; ld_data = 32'hAAAA5555;
    req_valid = 1'b1; req_addr = 32'hC;
    step();
    ld_en = 1'b0;
    chk_a("t4.old", 1'b1, 32'h0, 2'b00);
    step();
    req_valid = 1'b0;
    chk_a("t4.new", 1'b1, 32'hAAAA5555, 2'b00);
    chk_b("t4.old", 1'b1, 32'h0, 2'b00);
    step();
    chk_b("t4.new", 1'b1, 32'hAAAA5555, 2'b00);
    step();
    $display("txn t4: read-before-write collision");

    // Flush with two fetches in flight
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_addr = 32'h8;
    step();
    flush = 1'b1; req_addr = 32'hC;
    #1 check("t5.req_ready_flush", {31'd0, b_req_ready}, 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_b("t5.none", 1'b0, 32'h0, 2'b00);
      step();
    end
    req_valid = 1'b1; req_addr = 32'h4;
    #1 check("t5.req_ready_after", {31'd0, b_req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    step();
    chk_b("t5.refetch", 1'b1, 32'h24210004, 2'b00);
    step();
    chk_b("t5.idle", 1'b0, 32'h0, 2'b00);
    $display("txn t5: flush drops in-flight fetches");

    // Asynchronous reset under backpressure
    req_valid = 1'b1; req_addr = 32'h8;
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    chk_b("t6.held", 1'b1, 32'h00221820, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk_b("t6.rst", 1'b0, 32'h0, 2'b00);
    check("t6.req_ready_rst", {31'd0, b_req_ready}, 32'd0);
    ld_en = 1'b1; ld_addr = 8'd1; ld_data = 32'hDEADBEEF;
    step();
    ld_en = 1'b0;
    rst_n = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h4;
    #1 check("t6.req_ready_rel", {31'd0, b_req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk_a("t6.intact", 1'b1, 32'h24210004, 2'b00);
    step();
    chk_b("t6.intact", 1'b1, 32'h24210004, 2'b00);
    $display("txn t6: async reset keeps memory contents");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_fetch.md
Name: inst_rom_fetch

Overview:
Parametrised, loadable instruction memory with a pipelined fetch interface. It is the successor to the fixed 256-word combinational instruction ROM. It adds a synchronous read of configurable latency, valid/ready handshakes on the request and response sides, a program-load write port, flush, and fault reporting for misaligned and out-of-range fetches. It sits between the PC/fetch stage and the decode stage of the CPU.

Parameters:
ADDR_W, 32, width of the byte address on the fetch request.
DATA_W, 32, instruction width.
DEPTH_LOG2, 8, log2 of the word count (default 256 words).
READ_LAT, 1, pipeline depth from request acceptance to response valid. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  fetch request valid.
req_ready  out  1  fetch request accepted when req_valid && req_ready.
req_addr  in  ADDR_W  byte address of the instruction.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_inst  out  DATA_W  fetched instruction.
rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
flush  in  1  discard all in-flight fetches.
ld_en  in  1  program-load write strobe.
ld_addr  in  DEPTH_LOG2  word index to write.
ld_data  in  DATA_W  word to write.

Behaviour:
- Storage:
  - The array holds 2^DEPTH_LOG2 words and is all-zero (NOP) at time zero.
  - Reset does not alter array contents.
  - Word index = req_addr[DEPTH_LOG2+1:2].
- Load:
  - When ld_en=1, mem[ld_addr] <= ld_data at the edge.
  - ld_en is independent of the fetch handshake and of flush.
  - ld_en is ignored while rst_n=0.
- Read/load collision: a fetch read of the same word in the same cycle as a load returns the old data (read-before-write).
- Pipeline:
  - The pipeline has READ_LAT stages, each holding a valid bit, an instruction and a fault field.
  - advance = !rsp_valid || rsp_ready, i.e. the whole pipe moves together.
  - req_ready = advance && !flush. This is combinational from rsp_ready and flush; the path must be kept shallow.
- Latency and throughput:
  - A request accepted at edge N yields rsp_valid=1 after edge N+READ_LAT, provided advance holds throughout.
  - Throughput is one fetch per cycle with no backpressure.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all stages, rsp_inst and rsp_fault hold stable. This is the response-side stability rule.
- Bubbles: an idle request cycle (req_valid=0 with advance=1) inserts an invalid stage; bubbles are not compressed.
- Faults:
  - Misaligned is set when req_addr[1:0] != 0.
  - Out of range is set when req_addr[ADDR_W-1:DEPTH_LOG2+2] != 0.
  - The two bits are independent; both may be set.
  - Any faulted fetch returns rsp_inst = 0 and the array is not read.
  - A faulted response still requires the rsp handshake.
- Flush:
  - flush=1 clears every stage valid bit and rsp_valid at the next edge. It takes priority over rsp_ready and over a new request.
  - A response shown in the same cycle as flush is dropped, even if rsp_ready=1, and the consumer must ignore it.
  - The first cycle after flush deasserts, req_ready follows the advance rule again.
- Reset (asynchronous, any time including mid-operation):
  - All stage valids, rsp_valid, rsp_inst and rsp_fault go to 0 immediately.
  - req_ready = 0 while rst_n=0.
  - In-flight fetches are lost.
  - After release, the first request is acceptable on the first rising edge.
- Order: responses are returned strictly in request order.

Test Plan:
1. Load mem[1]=0x24210004 and mem[2]=0x00221820, then issue fetches at 0x4 and 0x8 back-to-back with READ_LAT=1 and rsp_ready=1 -> rsp_valid on the two consecutive cycles after acceptance, rsp_inst 0x24210004 then 0x00221820, rsp_fault=0.
2. Run the same stream with READ_LAT=2 and hold rsp_ready=0 for 3 cycles while the first response is valid -> req_ready=0, rsp_inst stable at 0x24210004; after rsp_ready=1 both responses drain in order with no loss or duplication.
3. Fetch 0x6, then 0x400 with DEPTH_LOG2=8, then 0x402 -> responses carry rsp_fault 01, 10 and 11 respectively, each with rsp_inst=0.
4. Load mem[3]=0xAAAA5555 in the same cycle as a fetch of 0xC (old value 0), then fetch 0xC again -> first rsp_inst=0, second 0xAAAA5555.
5. With two fetches in flight (READ_LAT=2), pulse flush for 1 cycle while req_valid=1 -> no response ever appears for either in-flight fetch, the request in the flush cycle is not accepted, and a fetch of 0x4 issued next returns normally.
6. Assert rst_n=0 between edges with a valid response held under backpressure -> rsp_valid, rsp_inst and rsp_fault drop to 0 immediately. After release, loaded contents are still intact: fetch of 0x4 returns 0x24210004.
